emitter: RTL and testbench

- Writer-side counterpart of the instruction parser. Takes decoded instruction records and serialises them into the packed byte format the parser reads from memory.
- Header byte is {op[2:0], d4, arg[3:0]}. Operand nibbles follow, packed two per byte.
- Sits between the code-generation/control logic and the program memory write port. Drives an auto-incrementing write address with a ready-stall handshake.

---
 rtl/emitter_pkg.sv | 48 ++++
 rtl/emitter_if.sv | 31 +++
 rtl/emitter_nib_packer.sv | 23 ++
 rtl/emitter.sv | 133 +++++++++++++
 tb/tb_emitter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/emitter_pkg.sv
// Shared definitions for the instruction emitter: state encoding, header
// field positions and the decoded record layout.
package emitter_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DAT0 = 3'd2;
  localparam logic [2:0] S_DAT1 = 3'd3;
  localparam logic [2:0] S_FULL = 3'd4;

  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    HDR  = S_HDR,
    DAT0 = S_DAT0,
    DAT1 = S_DAT1,
    FULL = S_FULL
  } state_e;

  // Header byte layout, shared with the parser side
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 5;
  localparam int D4_BIT  = 4;
  localparam int ARG_MSB = 3;

  localparam int NIB_W    = 4;
  localparam int MAX_NIBS = 3;
  localparam int NIBS_W   = MAX_NIBS * NIB_W;
  localparam logic [1:0] NCNT_MAX = 2'(MAX_NIBS);

  typedef struct packed {
    logic [OP_MSB-OP_LSB:0] op;
    logic                   d4;
    logic [ARG_MSB:0]       arg;
    logic [1:0]             ncnt;
    logic [NIBS_W-1:0]      nibs;
  } rec_t;

  // Assemble the header byte from a record
  function automatic logic [7:0] hdr_byte(rec_t r);
    logic [7:0] b;
    b                = '0;
    b[OP_MSB:OP_LSB] = r.op;
    b[D4_BIT]        = r.d4;
    b[ARG_MSB:0]     = r.arg;
    return b;
  endfunction

endpackage

// File: rtl/emitter_if.sv
// Record-input handshake and memory write bus of the emitter.
// master: the emitter itself; slave: the record source / memory side.
interface emitter_if #(
  parameter int AW = 8
);
  import emitter_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic              in_d4;
  logic [3:0]        in_arg;
  logic [1:0]        in_ncnt;
  logic [NIBS_W-1:0] in_nibs;

  logic [AW-1:0]     mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_ready;

  modport master (
    input  in_valid, in_op, in_d4, in_arg, in_ncnt, in_nibs, mem_ready,
    output in_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output in_valid, in_op, in_d4, in_arg, in_ncnt, in_nibs, mem_ready,
    input  in_ready, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/emitter_nib_packer.sv
// Combinational operand packer: selects the data byte for a given data
// state. Unused upper nibbles are padded with zero.
module emitter_nib_packer
  import emitter_pkg::*;
(
  input  state_e            state_i,
  input  logic [1:0]        ncnt_i,
  input  logic [NIBS_W-1:0] nibs_i,
  output logic [7:0]        data_o
);

  // Low nibble first; nib1 only present when at least two nibbles exist
  always_comb begin
    data_o = '0;
    case (state_i)
      DAT0: data_o = {(ncnt_i >= 2'd2) ? nibs_i[2*NIB_W-1:NIB_W] : 4'h0,
                      nibs_i[NIB_W-1:0]};
      DAT1: data_o = {4'h0, nibs_i[3*NIB_W-1:2*NIB_W]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/emitter.sv
// Instruction emitter: serialises decoded records into header + packed
// operand bytes on an auto-incrementing memory write port. Emission stops
// for good once the last address is written, until the next start.
module emitter
  import emitter_pkg::*;
#(
  parameter int            AW        = 8,
  parameter logic [AW-1:0] LAST_ADDR = {AW{1'b1}}
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  emitter_if.master     bus,
  output logic          busy,
  output logic          full,
  output logic          err
);

  state_e        state_q, state_d;
  rec_t          rec_q, rec_d;
  rec_t          rec_in;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          full_q, full_d;
  logic          err_q, err_d;
  logic          last_byte;
  logic [7:0]    data_byte;

  assign rec_in = '{op:   bus.in_op,
                    d4:   bus.in_d4,
                    arg:  bus.in_arg,
                    ncnt: bus.in_ncnt,
                    nibs: bus.in_nibs};

  // Data byte for whichever state is being entered next
  emitter_nib_packer u_packer (
    .state_i (state_d),
    .ncnt_i  (rec_d.ncnt),
    .nibs_i  (rec_d.nibs),
    .data_o  (data_byte)
  );

  // Next state, record capture, address advance and full/err flags
  always_comb begin
    state_d    = state_q;
    rec_d      = rec_q;
    mem_addr_d = mem_addr_q;
    full_d     = full_q;
    err_d      = err_q;
    last_byte  = 1'b0;
    if (start) begin
      // Start wins over everything, including a record offered this cycle
      state_d    = IDLE;
      mem_addr_d = base_addr;
      full_d     = 1'b0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            rec_d   = rec_in;
            state_d = HDR;
          end
        end
        HDR, DAT0, DAT1: begin
          if (bus.mem_ready) begin
            last_byte = ((state_q == HDR)  && (rec_q.ncnt == 2'd0)) ||
                        ((state_q == DAT0) && (rec_q.ncnt != NCNT_MAX)) ||
                        (state_q == DAT1);
            if (mem_addr_q == LAST_ADDR) begin
              // Region exhausted: hold the address, drop any remaining bytes
              full_d  = 1'b1;
              err_d   = err_q | ~last_byte;
              state_d = FULL;
            end else begin
              mem_addr_d = mem_addr_q + 1'b1;
              if (last_byte)              state_d = IDLE;
              else if (state_q == HDR)    state_d = DAT0;
              else                        state_d = DAT1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs derived from the state being entered
  always_comb begin
    mem_we_d    = (state_d == HDR) || (state_d == DAT0) || (state_d == DAT1);
    busy_d      = mem_we_d;
    in_ready_d  = (state_d == IDLE);
    mem_wdata_d = (state_d == HDR) ? hdr_byte(rec_d) : data_byte;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rec_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rec_q       <= rec_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign busy          = busy_q;
  assign full          = full_q;
  assign err           = err_q;

endmodule

// File: tb/tb_emitter.sv
// Scoreboard bench for the emitter: expected writes are queued as records
// are issued, a negedge monitor pops and compares each accepted write.
module tb_emitter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] base_addr;
  logic       busy, full, err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] exp_q[$];

  emitter_if #(.AW(8)) bus ();

  emitter #(.AW(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus.master),
    .busy      (busy),
    .full      (full),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Monitor: every accepted write must match the head of the queue
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(bus.mem_addr), 32'(e[15:8]));
        chk("write_data", 32'(bus.mem_wdata), 32'(e[7:0]));
      end
    end
  end

  task automatic push_exp(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_start(input logic [7:0] base);
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_rec(input logic [2:0] op, input logic d4, input logic [3:0] arg,
                          input logic [1:0] ncnt, input logic [11:0] nibs);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("send_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_d4    = d4;
    bus.in_arg   = arg;
    bus.in_ncnt  = ncnt;
    bus.in_nibs  = nibs;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.in_ready === 1'b1 && busy === 1'b0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_full();
    int n;
    n = 0;
    while (full !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("full_timeout", 32'(full), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    start         = 1'b0;
    base_addr     = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_d4     = 1'b0;
    bus.in_arg    = 4'h0;
    bus.in_ncnt   = 2'd0;
    bus.in_nibs   = 12'h000;
    bus.mem_ready = 1'b1;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_flags", 32'({busy, full, err}), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single header-only record
    do_start(8'h10);
    chk("start_addr", 32'(bus.mem_addr), 32'h10);
    push_exp(8'h10, 8'hBA);
    send_rec(3'b101, 1'b1, 4'hA, 2'd0, 12'h000);
    chk("hdr_busy", 32'(busy), 32'd1);
    chk("hdr_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("hdr_done_in_ready", 32'(bus.in_ready), 32'd1);
    chk("hdr_done_addr", 32'(bus.mem_addr), 32'h11);
    chk("hdr_done_busy", 32'(busy), 32'd0);

    // Packing: three nibbles, one nibble, two nibbles (nib2 ignored)
    push_exp(8'h11, 8'h07); push_exp(8'h12, 8'h21); push_exp(8'h13, 8'h03);
    send_rec(3'b000, 1'b0, 4'h7, 2'd3, 12'h321);
    wait_idle();
    push_exp(8'h14, 8'h02); push_exp(8'h15, 8'h0F);
    send_rec(3'b000, 1'b0, 4'h2, 2'd1, 12'h00F);
    wait_idle();
    push_exp(8'h16, 8'h61); push_exp(8'h17, 8'h54);
    send_rec(3'b011, 1'b0, 4'h1, 2'd2, 12'hF54);
    wait_idle();
    chk("pack_addr", 32'(bus.mem_addr), 32'h18);

    // Stall during DAT0
    push_exp(8'h18, 8'hD3); push_exp(8'h19, 8'h98);
    send_rec(3'b110, 1'b1, 4'h3, 2'd2, 12'h098);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_wdata", 32'(bus.mem_wdata), 32'h98);
      chk("stall_addr", 32'(bus.mem_addr), 32'h19);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_we", 32'(bus.mem_we), 32'd1);
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_done_addr", 32'(bus.mem_addr), 32'h1A);
    chk("stall_done_in_ready", 32'(bus.in_ready), 32'd1);

    // Full on the record's last byte: no truncation
    do_start(8'hFE);
    push_exp(8'hFE, 8'h35); push_exp(8'hFF, 8'hBA);
    send_rec(3'b001, 1'b1, 4'h5, 2'd2, 12'h0BA);
    wait_full();
    chk("fullA_flags", 32'({full, err}), 32'b10);
    chk("fullA_we", 32'(bus.mem_we), 32'd0);
    chk("fullA_addr", 32'(bus.mem_addr), 32'hFF);

    // Full with a byte still pending: truncated, err set
    do_start(8'hFE);
    chk("restart_full", 32'(full), 32'd0);
    push_exp(8'hFE, 8'hE0); push_exp(8'hFF, 8'h21);
    send_rec(3'b111, 1'b0, 4'h0, 2'd3, 12'hC21);
    wait_full();
    chk("fullB_flags", 32'({full, err}), 32'b11);
    chk("fullB_busy", 32'(busy), 32'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("fullB_in_ready", 32'(bus.in_ready), 32'd0);
      chk("fullB_we", 32'(bus.mem_we), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("fullB_addr", 32'(bus.mem_addr), 32'hFF);

    // Recovery via start
    do_start(8'h00);
    chk("recover_flags", 32'({full, err}), 32'd0);
    chk("recover_in_ready", 32'(bus.in_ready), 32'd1);
    chk("recover_addr", 32'(bus.mem_addr), 32'h00);

    // start and in_valid together: record must not be taken
    bus.in_valid = 1'b1;
    bus.in_op = 3'b111; bus.in_arg = 4'hF; bus.in_ncnt = 2'd0;
    do_start(8'h40);
    bus.in_valid = 1'b0;
    chk("start_valid_we", 32'(bus.mem_we), 32'd0);
    chk("start_valid_addr", 32'(bus.mem_addr), 32'h40);
    chk("start_valid_in_ready", 32'(bus.in_ready), 32'd1);
    push_exp(8'h40, 8'h49); push_exp(8'h41, 8'h05);
    send_rec(3'b010, 1'b0, 4'h9, 2'd1, 12'h005);
    wait_idle();
    chk("after_start_addr", 32'(bus.mem_addr), 32'h42);

    // Asynchronous reset in the middle of DAT0
    push_exp(8'h42, 8'h8F);
    send_rec(3'b100, 1'b0, 4'hF, 2'd1, 12'h006);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    chk("dat0_wdata", 32'(bus.mem_wdata), 32'h06);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_we_wdata", 32'({bus.mem_we, bus.mem_wdata}), 32'd0);
    chk("arst_addr", 32'(bus.mem_addr), 32'd0);
    chk("arst_flags", 32'({busy, full, err, bus.in_ready}), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("arst_rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_rel_addr", 32'(bus.mem_addr), 32'd0);
    chk("arst_rel_busy", 32'(busy), 32'd0);

    @(posedge clk); #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
